// File: rtl/m_store_buffer_pkg.sv
// Shared definitions for the M-stage store buffer: default depth, drain
// state encodings and the store-type codes used by the byte-enable stage.
package m_store_buffer_pkg;

   localparam int SB_DEPTH = 4;

   // Drain state machine encodings
   typedef enum logic {
      SB_IDLE = 1'b0,
      SB_BUSY = 1'b1
   } sb_state_e;

   // Store-type codes produced upstream by the byte-enable generator
   typedef enum logic [1:0] {
      ST_SB = 2'b00,
      ST_SH = 2'b01,
      ST_SW = 2'b10
   } sb_st_type_e;

endpackage

// File: rtl/m_store_buffer_if.sv
// Pipeline-side and memory-side signals of the store buffer.
// slave: the store buffer itself; master: the pipeline/memory environment.
interface m_store_buffer_if import m_store_buffer_pkg::*; #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = SB_DEPTH
);
   logic                     st_valid;
   logic [ADDR_W-1:0]        st_addr;
   logic [3:0]               st_byteen;
   logic [31:0]              st_wdata;
   logic                     ld_valid;
   logic [ADDR_W-1:0]        ld_addr;
   logic                     stall;
   logic                     mem_req;
   logic [ADDR_W-1:0]        mem_addr;
   logic [3:0]               mem_byteen;
   logic [31:0]              mem_wdata;
   logic                     mem_ack;
   logic                     empty;
   logic [$clog2(DEPTH):0]   count;

   modport slave (
      input  st_valid, st_addr, st_byteen, st_wdata, ld_valid, ld_addr, mem_ack,
      output stall, mem_req, mem_addr, mem_byteen, mem_wdata, empty, count
   );

   modport master (
      output st_valid, st_addr, st_byteen, st_wdata, ld_valid, ld_addr, mem_ack,
      input  stall, mem_req, mem_addr, mem_byteen, mem_wdata, empty, count
   );
endinterface

// File: rtl/m_store_buffer_sb_fifo.sv
// sb_fifo: DEPTH-entry store queue of {word addr, byteen, wdata}.
// With M_STORE_BUFFER_LOAD_BYPASS_EN defined it also exposes per-entry
// valid bits and word addresses for the load-bypass compare.
module sb_fifo import m_store_buffer_pkg::*; #(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = 30
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        push,
   input  logic                        pop,
   input  logic [AW-1:0]               in_waddr,
   input  logic [3:0]                  in_byteen,
   input  logic [31:0]                 in_wdata,
   output logic [AW-1:0]               head_waddr,
   output logic [3:0]                  head_byteen,
   output logic [31:0]                 head_wdata,
   output logic [AW-1:0]               nxt_waddr,
   output logic [3:0]                  nxt_byteen,
   output logic [31:0]                 nxt_wdata,
`ifdef M_STORE_BUFFER_LOAD_BYPASS_EN
   output logic [DEPTH-1:0]            vld,
   output logic [DEPTH-1:0][AW-1:0]    all_waddr,
`endif
   output logic [$clog2(DEPTH):0]      count,
   output logic                        full,
   output logic                        empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = AW + 36;

   logic [DEPTH-1:0][EW-1:0] mem;
   logic [PW-1:0]            wptr, rptr, rptr_nxt;

   assign rptr_nxt = rptr + PW'(1);

   // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem   <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= {in_waddr, in_byteen, in_wdata};
            wptr      <= wptr + PW'(1);
         end
         if (pop)
            rptr <= rptr_nxt;
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assign {head_waddr, head_byteen, head_wdata} = mem[rptr];
   assign {nxt_waddr, nxt_byteen, nxt_wdata}    = mem[rptr_nxt];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

`ifdef M_STORE_BUFFER_LOAD_BYPASS_EN
   // An entry is live when its distance from the read pointer is below count
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         vld[i]       = ({1'b0, PW'(i) - rptr} < count);
         all_waddr[i] = mem[i][EW-1:36];
      end
   end
`endif

endmodule

// File: rtl/m_store_buffer.sv
// m_store_buffer: queues M-stage stores and drains them to data memory over
// a req/ack handshake; stalls the pipeline when full or when a load could see
// stale memory. Optional macro M_STORE_BUFFER_LOAD_BYPASS_EN lets loads to
// words not held in the buffer proceed while it is non-empty.
module m_store_buffer import m_store_buffer_pkg::*; #(
   parameter int DEPTH  = SB_DEPTH,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   m_store_buffer_if.slave     bus
);
   localparam int AW = ADDR_W - 2;
   localparam int CW = $clog2(DEPTH) + 1;

   sb_state_e       state_q, state_d;
   logic            push, pop, full, empty, ld_hit;
   logic [CW-1:0]   count;
   logic [AW-1:0]   head_waddr, nxt_waddr, out_waddr_q, out_waddr_d;
   logic [3:0]      head_byteen, nxt_byteen, out_byteen_q, out_byteen_d;
   logic [31:0]     head_wdata, nxt_wdata, out_wdata_q, out_wdata_d;
`ifdef M_STORE_BUFFER_LOAD_BYPASS_EN
   logic [DEPTH-1:0]          vld;
   logic [DEPTH-1:0][AW-1:0]  all_waddr;
`endif

   // A full-stall blocks the store even if the head pops this same cycle
   assign push = bus.st_valid && (bus.st_byteen != 4'b0000) && !full;
   assign pop  = (state_q == SB_BUSY) && bus.mem_ack;

   sb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (push),
      .pop         (pop),
      .in_waddr    (bus.st_addr[ADDR_W-1:2]),
      .in_byteen   (bus.st_byteen),
      .in_wdata    (bus.st_wdata),
      .head_waddr  (head_waddr),
      .head_byteen (head_byteen),
      .head_wdata  (head_wdata),
      .nxt_waddr   (nxt_waddr),
      .nxt_byteen  (nxt_byteen),
      .nxt_wdata   (nxt_wdata),
`ifdef M_STORE_BUFFER_LOAD_BYPASS_EN
      .vld         (vld),
      .all_waddr   (all_waddr),
`endif
      .count       (count),
      .full        (full),
      .empty       (empty)
   );

`ifdef M_STORE_BUFFER_LOAD_BYPASS_EN
   // Load must wait only if a live entry targets the same word
   always_comb begin
      ld_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (vld[i] && (all_waddr[i] == bus.ld_addr[ADDR_W-1:2]))
            ld_hit = 1'b1;
   end
`else
   // Any buffered store may alias the load, so wait for a full drain
   always_comb ld_hit = !empty;
`endif

   // Stall from registered occupancy and M-stage inputs only; a load alongside
   // a store is illegal and ignored
   always_comb begin
      bus.stall = (bus.st_valid && (bus.st_byteen != 4'b0000) && full) ||
                  (bus.ld_valid && !bus.st_valid && ld_hit);
   end

   // Drain state and registered copy of the entry being offered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= SB_IDLE;
         out_waddr_q  <= '0;
         out_byteen_q <= '0;
         out_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         out_waddr_q  <= out_waddr_d;
         out_byteen_q <= out_byteen_d;
         out_wdata_q  <= out_wdata_d;
      end
   end

   // Next drain state; the offered entry is reloaded only on entry to BUSY
   // or after an ack, pulling from the next slot or the incoming store
   always_comb begin
      state_d      = state_q;
      out_waddr_d  = out_waddr_q;
      out_byteen_d = out_byteen_q;
      out_wdata_d  = out_wdata_q;
      case (state_q)
         SB_IDLE: begin
            if (!empty) begin
               state_d      = SB_BUSY;
               out_waddr_d  = head_waddr;
               out_byteen_d = head_byteen;
               out_wdata_d  = head_wdata;
            end else if (push) begin
               state_d      = SB_BUSY;
               out_waddr_d  = bus.st_addr[ADDR_W-1:2];
               out_byteen_d = bus.st_byteen;
               out_wdata_d  = bus.st_wdata;
            end
         end
         SB_BUSY: begin
            if (bus.mem_ack) begin
               if (count > CW'(1)) begin
                  out_waddr_d  = nxt_waddr;
                  out_byteen_d = nxt_byteen;
                  out_wdata_d  = nxt_wdata;
               end else if (push) begin
                  out_waddr_d  = bus.st_addr[ADDR_W-1:2];
                  out_byteen_d = bus.st_byteen;
                  out_wdata_d  = bus.st_wdata;
               end else begin
                  state_d      = SB_IDLE;
                  out_waddr_d  = '0;
                  out_byteen_d = '0;
                  out_wdata_d  = '0;
               end
            end
         end
         default: state_d = SB_IDLE;
      endcase
   end

   assign bus.mem_req    = (state_q == SB_BUSY);
   assign bus.mem_addr   = {out_waddr_q, 2'b00};
   assign bus.mem_byteen = out_byteen_q;
   assign bus.mem_wdata  = out_wdata_q;
   assign bus.empty      = empty;
   assign bus.count      = count;

endmodule

// File: tb/tb_m_store_buffer.sv
// Self-checking bench for m_store_buffer: directed stores/loads, expected
// memory writes queued at issue and compared by a separate write monitor.
module tb_m_store_buffer;
   import m_store_buffer_pkg::*;

`ifdef M_STORE_BUFFER_LOAD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   nchk = 0;
   int   nerr = 0;
   wr_t  exp_q[$];

   m_store_buffer_if #(.ADDR_W(32), .DEPTH(4)) bus ();

   m_store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      bus.st_valid  = 1'b1;
      bus.st_addr   = a;
      bus.st_byteen = be;
      bus.st_wdata  = d;
   endtask

   task automatic exp_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      wr_t e;
      e.a  = {a[31:2], 2'b00};
      e.be = be;
      e.d  = d;
      exp_q.push_back(e);
   endtask

   // Write monitor: every accepted memory write must match the queue head
   always @(negedge clk) begin
      wr_t e;
      if (!reset && bus.mem_req && bus.mem_ack) begin
         if (exp_q.size() == 0) begin
            nchk++;
            nerr++;
            $display("FAIL unexpected_write: got addr 0x%0h with no write expected", bus.mem_addr);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.mem_addr, e.a);
            chk("wr_byteen", 32'(bus.mem_byteen), 32'(e.be));
            chk("wr_data", bus.mem_wdata, e.d);
         end
      end
   end

   initial begin
      bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_byteen = '0; bus.st_wdata = '0;
      bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_req", 32'(bus.mem_req), 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_byteen", 32'(bus.mem_byteen), 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_stall", 32'(bus.stall), 0);

      // Single store, ack tied high
      @(posedge clk); #1;
      bus.mem_ack = 1'b1;
      st(32'h0000_1006, 4'b1100, 32'hBEEF_0000);
      exp_wr(32'h0000_1006, 4'b1100, 32'hBEEF_0000);
      @(negedge clk);
      chk("single_stall", 32'(bus.stall), 0);
      chk("single_req_lat0", 32'(bus.mem_req), 0);
      @(posedge clk); #1 bus.st_valid = 1'b0;
      @(negedge clk);
      chk("single_req", 32'(bus.mem_req), 1);
      chk("single_addr", bus.mem_addr, 32'h1004);
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_empty", 32'(bus.empty), 1);
      chk("single_idle", 32'(bus.mem_req), 0);

      // Suppressed store
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      st(32'h0000_2000, 4'b0000, 32'h1234_5678);
      @(negedge clk);
      chk("supp_stall", 32'(bus.stall), 0);
      @(posedge clk); #1 bus.st_valid = 1'b0;
      @(negedge clk);
      chk("supp_count", 32'(bus.count), 0);
      chk("supp_req", 32'(bus.mem_req), 0);

      // Fill to full, fifth store stalls
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         st(32'h3000 + 32'(4 * k), 4'b1111, 32'hA000_0000 + 32'(k));
         exp_wr(32'h3000 + 32'(4 * k), 4'b1111, 32'hA000_0000 + 32'(k));
         @(negedge clk);
         chk("fill_stall", 32'(bus.stall), (k == 4) ? 32'd1 : 32'd0);
      end
      chk("fill_count", 32'(bus.count), 4);
      @(posedge clk); #1 bus.mem_ack = 1'b1;
      @(negedge clk);
      chk("fullpop_count", 32'(bus.count), 4);
      chk("fullpop_stall", 32'(bus.stall), 1);
      @(posedge clk); #1 bus.mem_ack = 1'b0;
      @(negedge clk);
      chk("admit_count", 32'(bus.count), 3);
      chk("admit_stall", 32'(bus.stall), 0);
      @(posedge clk); #1 bus.st_valid = 1'b0;
      @(negedge clk);
      chk("refill_count", 32'(bus.count), 4);
      chk("refill_head", bus.mem_addr, 32'h3004);

      // Back-to-back drain
      @(posedge clk); #1 bus.mem_ack = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("drain_req", 32'(bus.mem_req), 1);
         chk("drain_addr", bus.mem_addr, 32'h3004 + 32'(4 * j));
         @(posedge clk); #1;
      end
      bus.mem_ack = 1'b0;
      @(negedge clk);
      chk("drain_idle", 32'(bus.mem_req), 0);
      chk("drain_empty", 32'(bus.empty), 1);

      // Load ordering
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         st(32'h1000 + 32'(4 * k), 4'b1111, 32'h1111_1111 * 32'(k + 1));
         exp_wr(32'h1000 + 32'(4 * k), 4'b1111, 32'h1111_1111 * 32'(k + 1));
      end
      @(posedge clk); #1;
      bus.st_valid = 1'b0; bus.ld_valid = 1'b1; bus.ld_addr = 32'h2000;
      @(negedge clk);
      chk("ld_far_stall", 32'(bus.stall), BYP ? 32'd0 : 32'd1);
      @(posedge clk); #1 bus.ld_addr = 32'h1006;
      @(negedge clk);
      chk("ld_near_stall", 32'(bus.stall), 1);
      @(posedge clk); #1;
      bus.ld_addr = 32'h2000; bus.mem_ack = 1'b1;
      @(negedge clk);
      chk("ld_drain2_stall", 32'(bus.stall), BYP ? 32'd0 : 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ld_lastack_stall", 32'(bus.stall), BYP ? 32'd0 : 32'd1);
      @(posedge clk); #1 bus.mem_ack = 1'b0;
      @(negedge clk);
      chk("ld_done_stall", 32'(bus.stall), 0);
      chk("ld_done_empty", 32'(bus.empty), 1);
      @(posedge clk); #1 bus.ld_valid = 1'b0;

      // Reset with writes pending
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         st(32'h4000 + 32'(4 * k), 4'b1111, 32'hC000_0000 + 32'(k));
      end
      @(posedge clk); #1 bus.st_valid = 1'b0;
      @(negedge clk);
      chk("prerst_req", 32'(bus.mem_req), 1);
      chk("prerst_count", 32'(bus.count), 3);
      @(posedge clk); #2 reset = 1'b1;
      #1;
      chk("midrst_req", 32'(bus.mem_req), 0);
      chk("midrst_count", 32'(bus.count), 0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      bus.mem_ack = 1'b1;
      st(32'h0000_5008, 4'b0011, 32'h0000_ABCD);
      exp_wr(32'h0000_5008, 4'b0011, 32'h0000_ABCD);
      @(posedge clk); #1 bus.st_valid = 1'b0;
      @(negedge clk);
      chk("postrst_req", 32'(bus.mem_req), 1);
      chk("postrst_addr", bus.mem_addr, 32'h5008);
      @(posedge clk); #1;
      @(negedge clk);
      chk("postrst_idle", 32'(bus.mem_req), 0);
      chk("all_writes_seen", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
